traffic_phase_sched: RTL
========================

Name: traffic_phase_sched

Overview:
- Tick-driven phase scheduler for a two-road intersection with car lights and walker lights.
- Sequences eight car phases, horizontal then vertical, using run-time programmable durations.
- Latches pedestrian button requests and issues walker WALK/FLASH/STOP codes.
- Sits between the CPU/config bus and the light-decode logic; downstream logic maps o_phase and the walker codes to lamp one-hots.

Parameters:
- CNT_W, 8, width of duration registers and remaining-time counter.
- GREEN_DEF, 20, reset value of the green duration, in ticks.
- YELLOW_DEF, 2, reset value of the yellow duration, in ticks.
- LEFT_DEF, 10, reset value of the left-turn duration, in ticks.
- FLASH_DEF, 6, reset value of the walker flash window at the end of green, in ticks.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; 1 = run, 0 = lights off (IDLE)
- tick  in  1  one-cycle timebase strobe (1 s); all durations count ticks
- ped_req_h  in  1  horizontal-crosswalk button, one-cycle pulse
- ped_req_v  in  1  vertical-crosswalk button, one-cycle pulse
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=GREEN, 1=YELLOW, 2=LEFT, 3=FLASH
- cfg_wdata  in  CNT_W  duration value
- o_phase  out  4  0=IDLE, 1=H_GREEN, 2=H_YEL1, 3=H_LEFT, 4=H_YEL2, 5=V_GREEN, 6=V_YEL1, 7=V_LEFT, 8=V_YEL2
- o_remain  out  CNT_W  ticks left in the current phase, minus 1
- o_phase_start  out  1  one-cycle pulse on every phase entry
- o_h_walker  out  2  0=OFF, 1=WALK, 2=STOP, 3=FLASH
- o_v_walker  out  2  same encoding as o_h_walker
- o_ped_pend  out  2  {h,v} latched requests not yet served

Behaviour:
- Reset (asynchronous, reset_n=0):
  - o_phase=IDLE, o_remain=0, o_phase_start=0, walkers=OFF, o_ped_pend=0.
  - Config registers load their *_DEF values.
- start=0: state returns to IDLE on the next clock edge; walkers=OFF; pending requests are cleared; config writes are still accepted.
- Leaving IDLE: in IDLE with start=1, the next edge enters H_GREEN. The first phase starts without waiting for a tick.
- Phase entry:
  - Active values are copied from the config registers (shadow load), so a mid-phase write takes effect at the next phase entry only.
  - o_remain loads max(dur,1)-1.
  - o_phase_start=1 for exactly that cycle.
- Counting: on each tick with o_remain>0, decrement. On a tick with o_remain==0, advance to the next phase on that same edge. V_YEL2 wraps to H_GREEN.
- Phase lengths are exactly max(dur,1) ticks. The full cycle is 2*(G+2Y+L) ticks.
- Walker windows:
  - The v-walker is served during H_GREEN; the h-walker is served during V_GREEN.
  - A served walker shows WALK while o_remain >= FLASH and FLASH while o_remain < FLASH.
  - If FLASH >= GREEN, the whole window is FLASH.
  - Outside its window, a walker shows STOP.
- Request latch:
  - A button pulse sets its pend bit at any time while start=1.
  - The pend bit is cleared on entry to the serving green phase.
  - A request arriving during its own green phase stays pending for the next cycle.
  - Simultaneous set and clear: the clear wins, and the new request is treated as served.
- cfg_we with an out-of-range cfg_addr is impossible (the field is 2 bits). Writes of 0 are stored as 0 and applied as 1.
- All outputs are registered, except o_h_walker/o_v_walker, which are combinational from state, o_remain and config.

Optional Feature:
- Macro TRAFFIC_PED_ACTUATED_EN.
- Defined: a walker window is granted only if its pend bit was set at entry to the serving green phase. Otherwise that walker shows STOP for the whole phase.
- Undefined: recall mode. Every green phase grants its walker window. The pend bits still latch and clear but do not gate the walker.

Decomposition:
- Shared package traffic_pkg holds:
  - the phase encodings and walker codes (OFF/WALK/STOP/FLASH);
  - the cfg address constants;
  - the car/walker lamp one-hot constants (C_RED, C_YELLOW, C_LEFT, C_GREEN, W_RED, W_GREEN).
- One sub-module, traffic_cfg_regs: the four config registers plus their shadow copies, loaded on phase entry.

Test Plan:
- Reset with defaults, start=1, tick every 4 clk → phases 1..8 last 20,2,10,2,20,2,10,2 ticks; H_GREEN re-entered after 68 ticks; one o_phase_start pulse per entry.
- Write GREEN=5 mid-H_GREEN → current H_GREEN keeps 20 ticks; the following V_GREEN lasts 5 ticks.
- Default config, recall build → v-walker WALK for 14 ticks then FLASH for 6 during H_GREEN; STOP in all other phases.
- Actuated build: ped_req_h pulse during H_LEFT → o_ped_pend=2'b10; cleared at V_GREEN entry; h-walker WALK/FLASH. Next V_GREEN with no request → STOP.
- Deassert start mid-V_LEFT → IDLE next edge, walkers OFF, pend=0. Reassert → H_GREEN with o_remain=19.
- Assert reset_n=0 asynchronously mid-phase → outputs reset without a clock edge; cfg reverts to defaults. Write YELLOW=0 → yellow phases last 1 tick.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic phase scheduler slice.
//   - phase_e   : car phase encoding driven on o_phase
//   - walker_e  : walker codes driven on o_h_walker / o_v_walker
//   - CFG_*     : config bus addresses
//   - C_* / W_* : lamp one-hot constants used by the downstream light decoder
//   - next_phase: phase succession, V_YEL2 wraps to H_GREEN
// Optional feature macro used by the slice: TRAFFIC_PED_ACTUATED_EN.
package traffic_pkg;

    typedef enum logic [3:0] {
        PH_IDLE    = 4'd0,
        PH_H_GREEN = 4'd1,
        PH_H_YEL1  = 4'd2,
        PH_H_LEFT  = 4'd3,
        PH_H_YEL2  = 4'd4,
        PH_V_GREEN = 4'd5,
        PH_V_YEL1  = 4'd6,
        PH_V_LEFT  = 4'd7,
        PH_V_YEL2  = 4'd8
    } phase_e;

    typedef enum logic [1:0] {
        WK_OFF   = 2'd0,
        WK_WALK  = 2'd1,
        WK_STOP  = 2'd2,
        WK_FLASH = 2'd3
    } walker_e;

    localparam logic [1:0] CFG_GREEN  = 2'd0;
    localparam logic [1:0] CFG_YELLOW = 2'd1;
    localparam logic [1:0] CFG_LEFT   = 2'd2;
    localparam logic [1:0] CFG_FLASH  = 2'd3;

    localparam logic [3:0] C_RED    = 4'b0001;
    localparam logic [3:0] C_YELLOW = 4'b0010;
    localparam logic [3:0] C_LEFT   = 4'b0100;
    localparam logic [3:0] C_GREEN  = 4'b1000;
    localparam logic [1:0] W_RED    = 2'b01;
    localparam logic [1:0] W_GREEN  = 2'b10;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_IDLE,
            PH_V_YEL2: n = PH_H_GREEN;
            default:   n = phase_e'(p + 4'd1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_cfg_regs.sv
// traffic_cfg_regs: run-time duration registers and their active copies.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cfg_we/addr/wdata     : config write port (0=GREEN 1=YELLOW 2=LEFT 3=FLASH)
//   load                  : phase-entry strobe; captures active copies
//   load_phase            : phase being entered
//   load_len_m1           : max(dur,1)-1 for load_phase from the live registers
//   act_green, act_flash  : active (clamped) values held for the current phase
// Yellow and left need no separate active copy: their only use is the
// counter preload, which is itself captured at entry.
// Used by traffic_phase_sched; see TRAFFIC_PED_ACTUATED_EN there.
module traffic_cfg_regs
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_DEF  = 20,
    parameter int unsigned YELLOW_DEF = 2,
    parameter int unsigned LEFT_DEF   = 10,
    parameter int unsigned FLASH_DEF  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             load,
    input  phase_e           load_phase,
    output logic [CNT_W-1:0] load_len_m1,
    output logic [CNT_W-1:0] act_green,
    output logic [CNT_W-1:0] act_flash
);

    logic [CNT_W-1:0] green_q, yellow_q, left_q, flash_q;
    logic [CNT_W-1:0] sel;

    // Stored values may be zero; they are applied as one.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            green_q  <= CNT_W'(GREEN_DEF);
            yellow_q <= CNT_W'(YELLOW_DEF);
            left_q   <= CNT_W'(LEFT_DEF);
            flash_q  <= CNT_W'(FLASH_DEF);
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_GREEN:  green_q  <= cfg_wdata;
                CFG_YELLOW: yellow_q <= cfg_wdata;
                CFG_LEFT:   left_q   <= cfg_wdata;
                default:    flash_q  <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_green <= at_least_one(CNT_W'(GREEN_DEF));
            act_flash <= at_least_one(CNT_W'(FLASH_DEF));
        end else if (load) begin
            act_green <= at_least_one(green_q);
            act_flash <= at_least_one(flash_q);
        end
    end

    always_comb begin
        sel = '0;
        case (load_phase)
            PH_H_GREEN, PH_V_GREEN:                       sel = green_q;
            PH_H_YEL1, PH_H_YEL2, PH_V_YEL1, PH_V_YEL2:   sel = yellow_q;
            PH_H_LEFT, PH_V_LEFT:                         sel = left_q;
            default:                                      sel = '0;
        endcase
        load_len_m1 = at_least_one(sel) - CNT_W'(1);
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: tick-driven eight-phase scheduler for a two-road
// intersection with walker lights and latched pedestrian requests.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : 1 = run, 0 = lights off (IDLE)
//   tick                  : one-cycle timebase strobe; durations count ticks
//   ped_req_h, ped_req_v  : crosswalk button pulses
//   cfg_we/addr/wdata     : duration config writes
//   o_phase               : current phase (traffic_pkg::phase_e)
//   o_remain              : ticks left in the phase, minus 1
//   o_phase_start         : one-cycle pulse on every phase entry
//   o_h_walker/o_v_walker : walker code (combinational)
//   o_ped_pend            : {h,v} latched requests not yet served
// Macro TRAFFIC_PED_ACTUATED_EN: when defined, a walker window opens only if
// its request was pending at entry to the serving green; otherwise every
// green grants its walker window.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_DEF  = 20,
    parameter int unsigned YELLOW_DEF = 2,
    parameter int unsigned LEFT_DEF   = 10,
    parameter int unsigned FLASH_DEF  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             tick,
    input  logic             ped_req_h,
    input  logic             ped_req_v,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [3:0]       o_phase,
    output logic [CNT_W-1:0] o_remain,
    output logic             o_phase_start,
    output logic [1:0]       o_h_walker,
    output logic [1:0]       o_v_walker,
    output logic [1:0]       o_ped_pend
);

    phase_e           phase_q, phase_d;
    logic             entry;
    logic [CNT_W-1:0] remain_d;
    logic [CNT_W-1:0] load_len_m1, act_green, act_flash;
    logic [1:0]       pend_d;
    logic             clr_h, clr_v;
    logic             h_win, v_win, walk_ok;

    traffic_cfg_regs #(
        .CNT_W      (CNT_W),
        .GREEN_DEF  (GREEN_DEF),
        .YELLOW_DEF (YELLOW_DEF),
        .LEFT_DEF   (LEFT_DEF),
        .FLASH_DEF  (FLASH_DEF)
    ) u_cfg (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .load        (entry),
        .load_phase  (phase_d),
        .load_len_m1 (load_len_m1),
        .act_green   (act_green),
        .act_flash   (act_flash)
    );

    always_comb begin
        phase_d = phase_q;
        entry   = 1'b0;
        if (!start) begin
            phase_d = PH_IDLE;
        end else if (phase_q == PH_IDLE) begin
            // First phase starts immediately, not on a tick.
            phase_d = PH_H_GREEN;
            entry   = 1'b1;
        end else if (tick && o_remain == '0) begin
            phase_d = next_phase(phase_q);
            entry   = 1'b1;
        end
    end

    // Kept apart from the phase decode: load_len_m1 depends on phase_d.
    always_comb begin
        remain_d = o_remain;
        if (!start) begin
            remain_d = '0;
        end else if (entry) begin
            remain_d = load_len_m1;
        end else if (tick && o_remain != '0) begin
            remain_d = o_remain - CNT_W'(1);
        end
    end

    // A request coinciding with entry to its serving green is cleared and
    // counts as served.
    always_comb begin
        clr_h  = entry && (phase_d == PH_V_GREEN);
        clr_v  = entry && (phase_d == PH_H_GREEN);
        pend_d = '0;
        if (start) begin
            pend_d[1] = (o_ped_pend[1] | ped_req_h) & ~clr_h;
            pend_d[0] = (o_ped_pend[0] | ped_req_v) & ~clr_v;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= PH_IDLE;
            o_remain      <= '0;
            o_phase_start <= 1'b0;
            o_ped_pend    <= '0;
        end else begin
            phase_q       <= phase_d;
            o_remain      <= remain_d;
            o_phase_start <= entry;
            o_ped_pend    <= pend_d;
        end
    end

    assign o_phase = phase_q;

`ifdef TRAFFIC_PED_ACTUATED_EN
    logic grant_h_q, grant_v_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_h_q <= 1'b0;
            grant_v_q <= 1'b0;
        end else if (!start) begin
            grant_h_q <= 1'b0;
            grant_v_q <= 1'b0;
        end else begin
            if (clr_h) grant_h_q <= o_ped_pend[1] | ped_req_h;
            if (clr_v) grant_v_q <= o_ped_pend[0] | ped_req_v;
        end
    end

    assign h_win = (phase_q == PH_V_GREEN) && grant_h_q;
    assign v_win = (phase_q == PH_H_GREEN) && grant_v_q;
`else
    assign h_win = (phase_q == PH_V_GREEN);
    assign v_win = (phase_q == PH_H_GREEN);
`endif

    // A flash window at least as long as green makes the whole window FLASH.
    assign walk_ok = (o_remain >= act_flash) && (act_flash < act_green);

    always_comb begin
        o_h_walker = WK_STOP;
        o_v_walker = WK_STOP;
        if (phase_q == PH_IDLE) begin
            o_h_walker = WK_OFF;
            o_v_walker = WK_OFF;
        end else begin
            if (h_win) o_h_walker = walk_ok ? WK_WALK : WK_FLASH;
            if (v_win) o_v_walker = walk_ok ? WK_WALK : WK_FLASH;
        end
    end

endmodule
